div_scheduler: RTL and testbench

Shares one sequential integer divider among N_CH zero-crossing channels, each of which needs a slope division (dt/dy) once per detected crossing. A round-robin arbiter picks one pending request, captures its operands, issues a single-cycle start to the divider, waits for the result, and routes the quotient back to the owning channel. A watchdog aborts operations the divider never completes. The block sits between the per-channel crossing detectors and a single divider instance.

---
 rtl/div_scheduler.sv | 172 +++++++++++++++++
 tb/tb_div_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one sequential divider among N_CH channels.
// It captures the winner's operands, issues a start pulse, and routes the result or a watchdog abort.
module div_scheduler #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [N_CH-1:0]       req_i,
  input  logic [N_CH*WIDTH-1:0] x_i,
  input  logic [N_CH*WIDTH-1:0] y_i,
  output logic [N_CH-1:0]       gnt_o,
  output logic [N_CH-1:0]       done_o,
  output logic [WIDTH-1:0]      q_o,
  output logic                  dbz_o,
  output logic                  timeout_o,
  output logic                  busy_o,
  output logic                  div_start_o,
  output logic [WIDTH-1:0]      div_x_o,
  output logic [WIDTH-1:0]      div_y_o,
  input  logic                  div_busy_i,
  input  logic                  div_valid_i,
  input  logic                  div_dbz_i,
  input  logic [WIDTH-1:0]      div_q_i
);

  localparam int unsigned PtrW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

  typedef logic [PtrW-1:0] ch_t;
  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e           state_q, state_d;
  ch_t              ptr_q, ptr_d;
  ch_t              owner_q, owner_d;
  logic             first_q, first_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [WIDTH-1:0] div_x_q, div_x_d;
  logic [WIDTH-1:0] div_y_q, div_y_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dbz_q, dbz_d;
  logic             to_q, to_d;
  logic [N_CH-1:0]  done_q, done_d;
  logic [N_CH-1:0]  owner_oh;

  logic             found;
  ch_t              winner;
  int unsigned      idx;
  logic [WIDTH-1:0] x_sel, y_sel;

  // First requesting channel at or after ptr_q, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = (32'(ptr_q) + i) % N_CH;
      if (!found && req_i[ch_t'(idx)]) begin
        found  = 1'b1;
        winner = ch_t'(idx);
      end
    end
  end

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (ch_t'(c) == winner) begin
        x_sel = x_i[c*WIDTH +: WIDTH];
        y_sel = y_i[c*WIDTH +: WIDTH];
      end
    end
  end

  assign owner_oh = {{(N_CH-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    first_d     = first_q;
    wd_d        = wd_q;
    div_x_d     = div_x_q;
    div_y_d     = div_y_q;
    q_d         = q_q;
    dbz_d       = dbz_q;
    to_d        = to_q;
    done_d      = '0;
    gnt_o       = '0;
    div_start_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          div_x_d = x_sel;
          div_y_d = y_sel;
          owner_d = winner;
          ptr_d   = (winner == ch_t'(N_CH - 1)) ? '0 : winner + ch_t'(1);
          first_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Any div_valid_i seen here belongs to an op that was already aborted.
        if (first_q) gnt_o = owner_oh;
        first_d = 1'b0;
        if (!div_busy_i) begin
          div_start_o = 1'b1;
          wd_d        = '0;
          state_d     = StWait;
        end
      end
      StWait: begin
        wd_d = wd_q + WdW'(1);
        if (div_valid_i) begin
          q_d     = div_q_i;
          dbz_d   = div_dbz_i;
          to_d    = 1'b0;
          done_d  = owner_oh;
          state_d = StIdle;
        end else if (wd_q == WdLast) begin
          q_d     = '0;
          dbz_d   = 1'b0;
          to_d    = 1'b1;
          done_d  = owner_oh;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      first_q <= 1'b0;
      wd_q    <= '0;
      div_x_q <= '0;
      div_y_q <= '0;
      q_q     <= '0;
      dbz_q   <= 1'b0;
      to_q    <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      first_q <= first_d;
      wd_q    <= wd_d;
      div_x_q <= div_x_d;
      div_y_q <= div_y_d;
      q_q     <= q_d;
      dbz_q   <= dbz_d;
      to_q    <= to_d;
      done_q  <= done_d;
    end
  end

  assign done_o    = done_q;
  assign q_o       = q_q;
  assign dbz_o     = dbz_q;
  assign timeout_o = to_q;
  assign busy_o    = (state_q != StIdle);
  assign div_x_o   = div_x_q;
  assign div_y_o   = div_y_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural latency-configurable divider.
module tb_div_scheduler;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req = '0;
  logic [N*W-1:0] x = '0, y = '0;
  logic [N-1:0]   gnt_o, done_o;
  logic [W-1:0]   q_o, div_x_o, div_y_o, div_q;
  logic           dbz_o, timeout_o, busy_o, div_start_o;
  logic           div_busy, div_valid, div_dbz;

  // Divider model: valid pulses L cycles after the start cycle; it ignores reset.
  int         lat = 3;
  bit         hang = 0, busy_force = 0, valid_force = 0;
  int         cnt = 0;
  logic       m_valid = 1'b0, m_dbz = 1'b0;
  logic [W-1:0] m_q = '0;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (div_start_o) begin
      if (div_y_o == 0) begin
        m_q <= 32'hDEADBEEF; m_dbz <= 1'b1;
      end else begin
        m_q <= div_x_o / div_y_o; m_dbz <= 1'b0;
      end
      if (lat <= 1) begin
        m_valid <= !hang; cnt <= 0;
      end else cnt <= lat - 1;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) m_valid <= !hang;
    end
  end

  assign div_busy  = busy_force | (cnt != 0);
  assign div_valid = m_valid | valid_force;
  assign div_q     = valid_force ? 32'h5555_5555 : m_q;
  assign div_dbz   = m_dbz;

  div_scheduler #(.N_CH(N), .WIDTH(W), .TIMEOUT_CYC(64)) dut (
    .clk_i(clk), .reset_ni(rst_n), .req_i(req), .x_i(x), .y_i(y),
    .gnt_o(gnt_o), .done_o(done_o), .q_o(q_o), .dbz_o(dbz_o), .timeout_o(timeout_o),
    .busy_o(busy_o), .div_start_o(div_start_o), .div_x_o(div_x_o), .div_y_o(div_y_o),
    .div_busy_i(div_busy), .div_valid_i(div_valid), .div_dbz_i(div_dbz), .div_q_i(div_q)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Protocol monitor: one-hot grants/dones, never both at once; pulse counters.
  bit proto_err = 0;
  int gnt_cnt = 0, done_cnt = 0, start_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(gnt_o) > 1 || $countones(done_o) > 1 || (gnt_o != 0 && done_o != 0))
        proto_err <= 1'b1;
      if (gnt_o != 0) gnt_cnt <= gnt_cnt + 1;
      if (done_o != 0) done_cnt <= done_cnt + 1;
      if (div_start_o) start_cnt <= start_cnt + 1;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int ch, input logic [W-1:0] xv, input logic [W-1:0] yv);
    x[ch*W +: W] = xv;
    y[ch*W +: W] = yv;
  endtask

  task automatic wait_gnt(input string nm, input logic [N-1:0] exp, input int exp_cyc,
                          input logic exp_start, output int gcyc);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (gnt_o != 0) break;
    end
    gcyc = cyc;
    chk({nm, "_gnt"}, gnt_o, exp);
    chk({nm, "_gnt_cyc"}, cyc, exp_cyc);
    chk({nm, "_start"}, div_start_o, exp_start);
  endtask

  task automatic wait_done(input string nm, input logic [N-1:0] exp, input int exp_cyc,
                           input logic [W-1:0] eq, input logic edbz, input logic eto,
                           output int dcyc);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_o != 0) break;
    end
    dcyc = cyc;
    chk({nm, "_done"}, done_o, exp);
    chk({nm, "_done_cyc"}, cyc, exp_cyc);
    chk({nm, "_q"}, q_o, eq);
    chk({nm, "_dbz"}, dbz_o, edbz);
    chk({nm, "_timeout"}, timeout_o, eto);
    chk({nm, "_busy_in_done"}, busy_o, 1'b0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, gnt_o, 0);
    chk({nm, "_done"}, done_o, 0);
    chk({nm, "_q"}, q_o, 0);
    chk({nm, "_dbz"}, dbz_o, 0);
    chk({nm, "_timeout"}, timeout_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_start"}, div_start_o, 0);
    chk({nm, "_divx"}, div_x_o, 0);
    chk({nm, "_divy"}, div_y_o, 0);
  endtask

  typedef struct {
    int           ch;
    logic [W-1:0] xv;
    logic [W-1:0] yv;
    int           l;
    logic [W-1:0] q;
    logic         dbz;
  } vec_t;

  vec_t vecs[5];
  int   t0, g, d, g0, s0, d0, last_done;
  int   rr_order[5];

  initial begin
    vecs[0] = '{2, 32'd1000,       32'd10,   34, 32'd100,        1'b0};
    vecs[1] = '{0, 32'd7,          32'd2,    3,  32'd3,          1'b0};
    vecs[2] = '{3, 32'hFFFF_FFFF,  32'd1,    5,  32'hFFFF_FFFF,  1'b0};
    vecs[3] = '{1, 32'd55,         32'd0,    4,  32'hDEAD_BEEF,  1'b1};
    vecs[4] = '{2, 32'd12345678,   32'd1000, 2,  32'd12345,      1'b0};
    rr_order = '{0, 1, 2, 3, 0};

    #1;
    chk_zero("reset");
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Round robin from ptr=0 with all four requesting; ch0 re-requests after its done.
    lat = 3;
    for (int c = 0; c < N; c++) set_ops(c, 32'((c + 2) * (c + 7)), 32'(c + 2));
    req = 4'b1111;
    t0 = cyc;
    last_done = t0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt($sformatf("rr%0d", k), 4'(1 << rr_order[k]), last_done + 1, 1'b1, g);
      step();
      req[rr_order[k]] = 1'b0;
      wait_done($sformatf("rr%0d", k), 4'(1 << rr_order[k]), g + 1 + lat,
                32'(rr_order[k] + 7), 1'b0, 1'b0, last_done);
      if (k == 0) begin
        step();
        req[0] = 1'b1;
      end
    end

    // Directed single-channel vectors.
    for (int v = 0; v < 5; v++) begin
      step();
      lat = vecs[v].l;
      set_ops(vecs[v].ch, vecs[v].xv, vecs[v].yv);
      req = '0;
      req[vecs[v].ch] = 1'b1;
      t0 = cyc;
      wait_gnt($sformatf("vec%0d", v), 4'(1 << vecs[v].ch), t0 + 1, 1'b1, g);
      step();
      req = '0;
      wait_done($sformatf("vec%0d", v), 4'(1 << vecs[v].ch), t0 + 2 + lat,
                vecs[v].q, vecs[v].dbz, 1'b0, d);
    end

    // Watchdog abort, then a stale valid during the next ISSUE must be ignored.
    step();
    hang = 1; lat = 3;
    set_ops(1, 32'd9, 32'd3);
    req = 4'b0010;
    t0 = cyc;
    wait_gnt("to", 4'b0010, t0 + 1, 1'b1, g);
    step();
    req = '0;
    wait_done("to", 4'b0010, g + 65, 32'd0, 1'b0, 1'b1, d);
    step();
    hang = 0;
    set_ops(2, 32'd20, 32'd4);
    req = 4'b0100;
    valid_force = 1;
    t0 = cyc;
    wait_gnt("stale", 4'b0100, t0 + 1, 1'b1, g);
    step();
    valid_force = 0;
    req = '0;
    wait_done("stale", 4'b0100, g + 1 + lat, 32'd5, 1'b0, 1'b0, d);

    // Divider busy for five ISSUE cycles: one grant, one delayed start.
    step();
    g0 = gnt_cnt; s0 = start_cnt;
    busy_force = 1;
    set_ops(0, 32'd81, 32'd9);
    req = 4'b0001;
    t0 = cyc;
    wait_gnt("busy", 4'b0001, t0 + 1, 1'b0, g);
    repeat (5) step();
    busy_force = 0;
    @(negedge clk);
    chk("busy_start_cyc", cyc, g + 5);
    chk("busy_start", div_start_o, 1'b1);
    step();
    req = '0;
    wait_done("busy", 4'b0001, g + 5 + 1 + lat, 32'd9, 1'b0, 1'b0, d);
    chk("busy_gnt_pulses", gnt_cnt - g0, 1);
    chk("busy_start_pulses", start_cnt - s0, 1);

    // Reset in the middle of WAIT (ptr is 3 afterwards unless reset clears it).
    step();
    lat = 34;
    set_ops(2, 32'd1000, 32'd10);
    req = 4'b0100;
    t0 = cyc;
    wait_gnt("rst", 4'b0100, t0 + 1, 1'b1, g);
    step();
    req = '0;
    repeat (5) step();
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (40) step();
    chk("midrst_no_done", done_cnt - d0, 0);
    lat = 3;
    set_ops(1, 32'd30, 32'd6);
    set_ops(3, 32'd44, 32'd4);
    req = 4'b1010;
    t0 = cyc;
    wait_gnt("post1", 4'b0010, t0 + 1, 1'b1, g);
    step();
    req[1] = 1'b0;
    wait_done("post1", 4'b0010, g + 1 + lat, 32'd5, 1'b0, 1'b0, d);
    wait_gnt("post3", 4'b1000, d + 1, 1'b1, g);
    step();
    req = '0;
    wait_done("post3", 4'b1000, g + 1 + lat, 32'd11, 1'b0, 1'b0, d);

    chk("protocol_onehot", proto_err, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule
